// File: rtl/multi_flex_counter_pkg.sv
// ============================================================================
// Module  : multi_flex_counter_pkg
// Purpose : Shared types for the multi-channel flex counter. Gives the
//           direction and overflow-mode control bits readable names.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_flex_counter_pkg;

    // Counting direction, taken directly from the per-channel dir input bit.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Behaviour at the terminal value, taken from the per-channel sat_mode bit.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage : multi_flex_counter_pkg

`default_nettype wire

// File: rtl/multi_flex_counter_ch.sv
// ============================================================================
// Module  : flex_counter_ch
// Purpose : One counter channel. It has up/down counting, parallel load,
//           wrap or saturate at the terminal value, a registered rollover
//           flag and a one-cycle wrap pulse.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           clear              - synchronous clear (beats load and enable)
//           load, load_val     - parallel load (beats enable)
//           count_enable       - advance the count this cycle
//           dir                - 1 = down, 0 = up
//           sat_mode           - 1 = saturate, 0 = wrap
//           rollover_val       - terminal value counting up / reload value down
//           count_out          - registered count
//           rollover_flag      - registered: count equals terminal
//           wrap_pulse         - registered one-cycle wrap event
//           rollover_next      - next value of rollover_flag (for the summary)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flex_counter_ch
    import multi_flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    count_enable,
    input  logic                    dir,
    input  logic                    sat_mode,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse,
    output logic                    rollover_next
);

    localparam logic [NUM_CNT_BITS-1:0] C_ONE = NUM_CNT_BITS'(1);

    dir_e                    w_dir;
    mode_e                   w_mode;
    logic [NUM_CNT_BITS-1:0] w_count_d;
    logic [NUM_CNT_BITS-1:0] w_terminal;
    logic                    w_rollover_flag_d;
    logic                    w_wrap_pulse_d;

    logic [NUM_CNT_BITS-1:0] r_count_q;
    logic                    r_rollover_flag_q;
    logic                    r_wrap_pulse_q;

    assign w_dir  = dir_e'(dir);
    assign w_mode = mode_e'(sat_mode);

    always_comb begin
        w_count_d         = r_count_q;
        w_wrap_pulse_d    = 1'b0;
        w_terminal        = rollover_val;
        w_rollover_flag_d = 1'b0;

        if (clear) begin
            w_count_d = '0;
        end else if (load) begin
            w_count_d = load_val;
        end else if (count_enable) begin
            if (w_dir == DIR_UP) begin
                // Compare for equality only, so a load above the terminal
                // counts through the top of the range and back round.
                if (r_count_q == rollover_val) begin
                    if (w_mode == MODE_WRAP) begin
                        w_count_d      = C_ONE;
                        w_wrap_pulse_d = 1'b1;
                    end
                end else begin
                    w_count_d = r_count_q + C_ONE;
                end
            end else begin
                // Down-counting terminates at 1. A count of 0 (after clear
                // or reset) reloads as well, which avoids underflow.
                if (r_count_q <= C_ONE) begin
                    if (w_mode == MODE_WRAP) begin
                        w_count_d      = rollover_val;
                        w_wrap_pulse_d = 1'b1;
                    end
                end else begin
                    w_count_d = r_count_q - C_ONE;
                end
            end
        end

        // The flag uses this cycle's direction and terminal. It applies to
        // the value the count is about to take.
        w_terminal        = (w_dir == DIR_DOWN) ? C_ONE : rollover_val;
        w_rollover_flag_d = (w_count_d == w_terminal) && !clear;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q         <= '0;
            r_rollover_flag_q <= 1'b0;
            r_wrap_pulse_q    <= 1'b0;
        end else begin
            r_count_q         <= w_count_d;
            r_rollover_flag_q <= w_rollover_flag_d;
            r_wrap_pulse_q    <= w_wrap_pulse_d;
        end
    end

    assign count_out     = r_count_q;
    assign rollover_flag = r_rollover_flag_q;
    assign wrap_pulse    = r_wrap_pulse_q;
    assign rollover_next = w_rollover_flag_d;

endmodule : flex_counter_ch

`default_nettype wire

// File: rtl/multi_flex_counter.sv
// ============================================================================
// Module  : multi_flex_counter
// Purpose : NUM_CHANNELS independent flex counters with one registered
//           any-channel rollover summary.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           clear/load/count_enable  - per-channel controls (bit i = ch i)
//           dir/sat_mode             - per-channel direction and mode
//           load_val_flat            - per-channel load values (packed)
//           rollover_val_flat        - per-channel terminal values (packed)
//           count_out_flat           - per-channel registered counts
//           rollover_flag            - per-channel registered terminal flag
//           wrap_pulse               - per-channel registered wrap event
//           any_rollover             - registered OR of the next flag values
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_flex_counter
    import multi_flex_counter_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CHANNELS-1:0]              clear,
    input  logic [NUM_CHANNELS-1:0]              load,
    input  logic [NUM_CHANNELS-1:0]              count_enable,
    input  logic [NUM_CHANNELS-1:0]              dir,
    input  logic [NUM_CHANNELS-1:0]              sat_mode,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val_flat,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val_flat,
    output logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out_flat,
    output logic [NUM_CHANNELS-1:0]              rollover_flag,
    output logic [NUM_CHANNELS-1:0]              wrap_pulse,
    output logic                                 any_rollover
);

    logic [NUM_CHANNELS-1:0] w_rollover_next;
    logic                    w_any_rollover_d;
    logic                    r_any_rollover_q;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        flex_counter_ch #(
            .NUM_CNT_BITS (NUM_CNT_BITS)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .clear         (clear[i]),
            .load          (load[i]),
            .count_enable  (count_enable[i]),
            .dir           (dir[i]),
            .sat_mode      (sat_mode[i]),
            .load_val      (load_val_flat[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_val  (rollover_val_flat[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .count_out     (count_out_flat[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_flag (rollover_flag[i]),
            .wrap_pulse    (wrap_pulse[i]),
            .rollover_next (w_rollover_next[i])
        );
    end

    // The summary is built from the next flag values. This keeps it aligned
    // with rollover_flag instead of one cycle behind it.
    always_comb begin
        w_any_rollover_d = |w_rollover_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_rollover_q <= 1'b0;
        end else begin
            r_any_rollover_q <= w_any_rollover_d;
        end
    end

    assign any_rollover = r_any_rollover_q;

endmodule : multi_flex_counter

`default_nettype wire

// File: tb/tb_multi_flex_counter.sv
// ============================================================================
// Module  : tb_multi_flex_counter
// Purpose : Self-checking bench for multi_flex_counter (4 channels x 4 bits).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_flex_counter;

    localparam int NC   = 4;
    localparam int W    = 4;
    localparam int MODV = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   clear, load, en, dir, sat;
    logic [NC*W-1:0] lv_flat, rv_flat;
    logic [NC*W-1:0] count_out_flat;
    logic [NC-1:0]   rollover_flag, wrap_pulse;
    logic            any_rollover;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_cnt  [NC];
    bit m_flag [NC];
    bit m_wrap [NC];
    bit m_any;
    bit m_valid = 1'b0;

    int e_up_cnt  [6] = '{1, 2, 3, 4, 5, 1};
    int e_up_flag [6] = '{0, 0, 0, 0, 1, 0};
    int e_up_wrap [6] = '{0, 0, 0, 0, 0, 1};
    int e_dn_cnt  [4] = '{2, 1, 3, 2};
    int e_dn_flag [4] = '{0, 1, 0, 0};
    int e_dn_wrap [4] = '{0, 0, 1, 0};
    int e_sat_cnt [6] = '{1, 2, 3, 4, 4, 4};
    int e_sat_flag[6] = '{0, 0, 0, 1, 1, 1};

    always #5 clk = ~clk;

    multi_flex_counter #(
        .NUM_CHANNELS (NC),
        .NUM_CNT_BITS (W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .clear             (clear),
        .load              (load),
        .count_enable      (en),
        .dir               (dir),
        .sat_mode          (sat),
        .load_val_flat     (lv_flat),
        .rollover_val_flat (rv_flat),
        .count_out_flat    (count_out_flat),
        .rollover_flag     (rollover_flag),
        .wrap_pulse        (wrap_pulse),
        .any_rollover      (any_rollover)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(count_out_flat[ch*W +: W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: applies the counter rules to plain integers on each rising edge.
    always @(posedge clk) begin
        int r, c, n, t;
        bit wp, any;
        any = 1'b0;
        for (int i = 0; i < NC; i++) begin
            r  = int'(rv_flat[i*W +: W]);
            c  = m_cnt[i];
            n  = c;
            wp = 1'b0;
            if (rst) begin
                n = 0;
            end else if (clear[i]) begin
                n = 0;
            end else if (load[i]) begin
                n = int'(lv_flat[i*W +: W]);
            end else if (en[i]) begin
                if (!dir[i]) begin
                    if (c == r) begin
                        if (!sat[i]) begin n = 1; wp = 1'b1; end
                    end else begin
                        n = (c + 1) % MODV;
                    end
                end else begin
                    if (c <= 1) begin
                        if (!sat[i]) begin n = r; wp = 1'b1; end
                    end else begin
                        n = c - 1;
                    end
                end
            end
            t         = dir[i] ? 1 : r;
            m_flag[i] = !rst && !clear[i] && (n == t);
            m_wrap[i] = wp;
            m_cnt[i]  = n;
            any       = any | m_flag[i];
        end
        m_any = any;
        if (rst) m_valid = 1'b1;
    end

    // Compare every cycle once the model has seen reset.
    always @(negedge clk) begin
        logic [NC-1:0] mf, mw;
        if (m_valid) begin
            for (int i = 0; i < NC; i++) begin
                mf[i] = m_flag[i];
                mw[i] = m_wrap[i];
                check($sformatf("model count ch%0d", i), cnt(i), 32'(m_cnt[i]));
            end
            check("model rollover_flag", 32'(rollover_flag), 32'(mf));
            check("model wrap_pulse", 32'(wrap_pulse), 32'(mw));
            check("model any_rollover", 32'(any_rollover), 32'(m_any));
        end
    end

    initial begin
        rst     = 1'b1;
        clear   = '0;
        load    = '0;
        en      = '0;
        dir     = 4'b0010;
        sat     = 4'b0100;
        lv_flat = '0;
        rv_flat = {4'd2, 4'd4, 4'd3, 4'd5};

        tick();
        tick();
        check("reset counts", 32'(count_out_flat), 32'h0);
        check("reset flags", 32'(rollover_flag), 32'h0);
        check("reset wrap", 32'(wrap_pulse), 32'h0);
        check("reset any", 32'(any_rollover), 32'h0);

        // Up wrap on ch0, R=5
        rst   = 1'b0;
        en[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("up cnt step%0d", k), cnt(0), 32'(e_up_cnt[k]));
            check($sformatf("up flag step%0d", k), 32'(rollover_flag[0]), 32'(e_up_flag[k]));
            check($sformatf("up wrap step%0d", k), 32'(wrap_pulse[0]), 32'(e_up_wrap[k]));
        end
        en[0] = 1'b0;

        // Down wrap on ch1, R=3
        load[1]      = 1'b1;
        lv_flat[7:4] = 4'd3;
        tick();
        check("down load", cnt(1), 32'd3);
        load[1] = 1'b0;
        en[1]   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("down cnt step%0d", k), cnt(1), 32'(e_dn_cnt[k]));
            check($sformatf("down flag step%0d", k), 32'(rollover_flag[1]), 32'(e_dn_flag[k]));
            check($sformatf("down wrap step%0d", k), 32'(wrap_pulse[1]), 32'(e_dn_wrap[k]));
        end
        en[1] = 1'b0;

        // Saturate on ch2, R=4
        en[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("sat cnt step%0d", k), cnt(2), 32'(e_sat_cnt[k]));
            check($sformatf("sat flag step%0d", k), 32'(rollover_flag[2]), 32'(e_sat_flag[k]));
            check($sformatf("sat wrap step%0d", k), 32'(wrap_pulse[2]), 32'h0);
        end
        en[2] = 1'b0;

        // Priority on ch0: clear beats load beats enable
        clear[0]     = 1'b1;
        load[0]      = 1'b1;
        en[0]        = 1'b1;
        lv_flat[3:0] = 4'd9;
        tick();
        check("prio clear cnt", cnt(0), 32'd0);
        check("prio clear flag", 32'(rollover_flag[0]), 32'h0);
        clear[0] = 1'b0;
        tick();
        check("prio load cnt", cnt(0), 32'd9);
        load[0] = 1'b0;

        // Loaded above R=5: counts 10..15,0..5 with no early wrap
        repeat (12) tick();
        check("above R cnt", cnt(0), 32'd5);
        check("above R flag", 32'(rollover_flag[0]), 32'h1);
        tick();
        check("above R wrap cnt", cnt(0), 32'd1);
        check("above R wrap pulse", 32'(wrap_pulse[0]), 32'h1);
        en[0] = 1'b0;

        // Independence and summary: only ch3 (R=2) reaches terminal
        clear = 4'b0111;
        tick();
        clear = '0;
        en[3] = 1'b1;
        tick();
        tick();
        check("indep counts", 32'(count_out_flat), 32'h2000);
        check("indep flags", 32'(rollover_flag), 32'h8);
        check("indep any", 32'(any_rollover), 32'h1);
        en[3] = 1'b0;

        // R=0 counting down in wrap mode on ch1: stays 0, pulses each cycle
        rv_flat[7:4] = 4'd0;
        en[1]        = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("r0 down cnt step%0d", k), cnt(1), 32'd0);
            check($sformatf("r0 down wrap step%0d", k), 32'(wrap_pulse[1]), 32'h1);
        end
        en[1] = 1'b0;

        // Mid-run reset at count 7 on ch0, R=10
        rv_flat[3:0] = 4'd10;
        load[0]      = 1'b1;
        lv_flat[3:0] = 4'd5;
        tick();
        load[0] = 1'b0;
        en[0]   = 1'b1;
        tick();
        tick();
        check("midrst pre cnt", cnt(0), 32'd7);
        rst = 1'b1;
        tick();
        check("midrst counts", 32'(count_out_flat), 32'h0);
        check("midrst flags", 32'(rollover_flag), 32'h0);
        check("midrst wrap", 32'(wrap_pulse), 32'h0);
        check("midrst any", 32'(any_rollover), 32'h0);
        rst = 1'b0;
        tick();
        check("midrst restart cnt", cnt(0), 32'd1);
        en = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_multi_flex_counter

`default_nettype wire
